approx_div_sched: RTL

Sequencing and arbitration controller for one shared combinational 16/8 array divider (exact or approximate variant, e.g. approx_div_113_15 array).
- Accepts divide requests from two requesters over valid/ready.
- Arbitrates round-robin between them.
- Holds operands stable on the array for a programmable settle time, then captures q/r.
- Returns the result with a requester tag, plus divide-by-zero and quotient-overflow flags.

---
 rtl/div_sched_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 36 +++
 rtl/approx_div_sched.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/div_sched_pkg.sv
// Shared definitions for the approximate-divider scheduler.
//   state_t  : controller states (IDLE, SETTLE, HOLD)
//   DZ_QUOT  : quotient reported for a zero divisor (all ones, truncated by user)
//   ovf_chk  : exact quotient-overflow test on the upper dividend half
package div_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Widest divisor supported by the shared helpers below.
  localparam int MAX_D_W = 32;

  localparam logic [MAX_D_W-1:0] DZ_QUOT = '1;

  // The true quotient needs more than D_W bits exactly when the upper half of
  // the dividend is not smaller than the divisor. A zero divisor is reported
  // through the divide-by-zero flag instead, so it never flags overflow.
  function automatic logic ovf_chk(input logic [MAX_D_W-1:0] n_hi,
                                   input logic [MAX_D_W-1:0] d);
    return (d != '0) && (n_hi >= d);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-port round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   req[1:0]   : request lines
//   advance    : a grant was consumed this cycle; rotate priority
//   grant[1:0] : one-hot grant (all zero when nothing requests)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Port that wins a tie; starts at port 0 after reset.
  logic prio;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // After granting port 0 the other port gets the tie, and vice versa.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      prio <= grant[0];
    end
  end

endmodule

// File: rtl/approx_div_sched.sv
// Sequencing/arbitration controller for one shared combinational N_W/D_W
// array divider (exact or approximate).
//   clk, rst_n           : clock, synchronous active-low reset
//   req0_* / req1_*      : two valid/ready request ports (dividend n, divisor d)
//   rsp_*                : result with requester id, q, r, divide-by-zero and
//                          quotient-overflow flags; held until rsp_ready
//   div_n/div_d          : operands driven to the external array
//   div_q/div_r          : array results, captured after SETTLE_CYCLES
//   busy                 : controller is not idle
module approx_div_sched
  import div_sched_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int N_W           = 16,
  parameter int D_W           = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N_W-1:0] req0_n,
  input  logic [D_W-1:0] req0_d,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N_W-1:0] req1_n,
  input  logic [D_W-1:0] req1_d,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [D_W-1:0] rsp_q,
  output logic [D_W-1:0] rsp_r,
  output logic           rsp_dz,
  output logic           rsp_ovf,
  output logic [N_W-1:0] div_n,
  output logic [D_W-1:0] div_d,
  input  logic [D_W-1:0] div_q,
  input  logic [D_W-1:0] div_r,
  output logic           busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t         state, state_nxt;
  logic [1:0]     req_vec;
  logic [1:0]     grant;
  logic           accept;
  logic           capture;
  logic [N_W-1:0] sel_n;
  logic [D_W-1:0] sel_d;

  logic [N_W-1:0] n_p0;
  logic [D_W-1:0] d_p0;
  logic [CNT_W-1:0] cnt_p0;

  assign req_vec = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_vec),
    .advance (accept),
    .grant   (grant)
  );

  // Operands of the port the arbiter currently favours.
  assign sel_n = grant[1] ? req1_n : req0_n;
  assign sel_d = grant[1] ? req1_d : req0_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ready is gated by reset so nothing appears accepted while in reset.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready = grant[0] & rst_n;
        req1_ready = grant[1] & rst_n;
        accept     = (grant != 2'b00);
        if (accept) begin
          state_nxt = (sel_d == '0) ? HOLD : SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_p0 == '0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign div_n     = n_p0;
  assign div_d     = d_p0;

  // Stage p0: operands registered at accept and held on the array until the
  // response is taken; the zero-divisor result is formed here directly.
  // Stage p1: array outputs captured into the response registers once the
  // settle counter expires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_p0    <= '0;
      d_p0    <= '0;
      cnt_p0  <= '0;
      rsp_id  <= 1'b0;
      rsp_q   <= '0;
      rsp_r   <= '0;
      rsp_dz  <= 1'b0;
      rsp_ovf <= 1'b0;
    end else if (accept) begin
      n_p0   <= sel_n;
      d_p0   <= sel_d;
      rsp_id <= grant[1];
      cnt_p0 <= CNT_W'(SETTLE_CYCLES - 1);
      if (sel_d == '0) begin
        rsp_q   <= DZ_QUOT[D_W-1:0];
        rsp_r   <= sel_n[D_W-1:0];
        rsp_dz  <= 1'b1;
        rsp_ovf <= 1'b0;
      end
    end else if (state == SETTLE) begin
      if (capture) begin
        rsp_q   <= div_q;
        rsp_r   <= div_r;
        rsp_dz  <= 1'b0;
        rsp_ovf <= ovf_chk(MAX_D_W'(n_p0[N_W-1:D_W]), MAX_D_W'(d_p0));
      end else begin
        cnt_p0 <= cnt_p0 - 1'b1;
      end
    end
  end

endmodule
